// File: rtl/clockbox_pkg.sv
// Shared clockbox constants and button channel indices.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clockbox_pkg;

    // Channel order on the raw button bus {start, stop, power, mode}
    typedef enum logic [1:0] {
        BTN_MODE  = 2'd0,
        BTN_POWER = 2'd1,
        BTN_STOP  = 2'd2,
        BTN_START = 2'd3
    } btn_idx_t;

    localparam int CLK_HZ              = 10000;
    // 20 ms of stable level before a change is accepted
    localparam int DEBOUNCE_CYCLES_DEF = CLK_HZ / 50;
    // 2 s of debounced hold counts as a long press
    localparam int LONG_CYCLES_DEF     = CLK_HZ * 2;
    localparam int N_BTN_DEF           = 4;

endpackage

// File: rtl/btn_channel.sv
// One button: 2-flop synchroniser, counter debounce, press/short/long event pulses.
// Latency: level and press appear DEBOUNCE_CYCLES+1 edges after raw is first sampled stable.
// Backpressure: none; outputs are free-running registered pulses/levels.
module btn_channel
    import clockbox_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level_o,
    output logic press_o,
    output logic short_o,
    output logic long_o
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    logic              s1_q, s1_d;
    logic              s2_q, s2_d;
    logic              level_q, level_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              long_fired_q, long_fired_d;
    logic              press_q, press_d;
    logic              short_q, short_d;
    logic              long_q, long_d;

    // Next-state: synchroniser shift, debounce count, hold count and event decode
    always_comb begin
        s1_d     = raw;
        s2_d     = s1_q;

        // Any sample equal to the current level wipes accumulated credit
        level_d  = level_q;
        db_cnt_d = '0;
        if (s2_q != level_q) begin
            if (db_cnt_q == DB_LAST) begin
                level_d = s2_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_ONE;
            end
        end

        // Saturating hold time of the debounced press
        hold_cnt_d = '0;
        if (level_q) begin
            hold_cnt_d = (hold_cnt_q == HOLD_MAX) ? hold_cnt_q : hold_cnt_q + HOLD_ONE;
        end

        press_d = ~level_q & level_d;
        // A release landing on the long threshold reports as short, keeping pulses exclusive
        long_d  = level_q & level_d & (hold_cnt_q == HOLD_LAST);
        short_d = level_q & ~level_d & ~long_fired_q;

        long_fired_d = long_fired_q;
        if (long_d) begin
            long_fired_d = 1'b1;
        end
        if (level_q & ~level_d) begin
            long_fired_d = 1'b0;
        end
    end

    // State registers with synchronous reset; a held button re-presses after reset
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            level_q      <= 1'b0;
            db_cnt_q     <= '0;
            hold_cnt_q   <= '0;
            long_fired_q <= 1'b0;
            press_q      <= 1'b0;
            short_q      <= 1'b0;
            long_q       <= 1'b0;
        end else begin
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            level_q      <= level_d;
            db_cnt_q     <= db_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            long_fired_q <= long_fired_d;
            press_q      <= press_d;
            short_q      <= short_d;
            long_q       <= long_d;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;
    assign short_o = short_q;
    assign long_o  = long_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions N_BTN raw push-buttons into debounced levels and press/short/long pulses.
// Latency: DEBOUNCE_CYCLES+1 edges from stable raw sample to level/press.
// Backpressure: none; each channel runs independently every cycle.
module button_conditioner
    import clockbox_pkg::*;
#(
    parameter int N_BTN           = N_BTN_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_short,
    output logic [N_BTN-1:0] btn_long
);

    // One independent conditioning channel per button
    for (genvar g = 0; g < N_BTN; g++) begin : g_chan
        btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES)
        ) u_chan (
            .clock   (clock),
            .reset   (reset),
            .raw     (btn_raw[g]),
            .level_o (btn_level[g]),
            .press_o (btn_press[g]),
            .short_o (btn_short[g]),
            .long_o  (btn_long[g])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] btn_raw;
    logic [3:0] btn_level, btn_press, btn_short, btn_long;

    logic [3:0] raw_full;
    logic [3:0] level_full, press_full, short_full, long_full;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    button_conditioner #(
        .N_BTN           (4),
        .DEBOUNCE_CYCLES (8),
        .LONG_CYCLES     (40)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .btn_raw   (btn_raw),
        .btn_level (btn_level),
        .btn_press (btn_press),
        .btn_short (btn_short),
        .btn_long  (btn_long)
    );

    button_conditioner dut_full (
        .clock     (clock),
        .reset     (reset),
        .btn_raw   (raw_full),
        .btn_level (level_full),
        .btn_press (press_full),
        .btn_short (short_full),
        .btn_long  (long_full)
    );

    // Drive raw, advance one edge, sample 1 time unit later
    task automatic step(input logic [3:0] raw);
        btn_raw = raw;
        @(posedge clock);
        #1;
    endtask

    task automatic release_all();
        for (int i = 0; i < 30; i++) step(4'h0);
        tests_run++;
        if (btn_level !== 4'h0) begin
            tests_failed++;
            $display("FAIL release_level: got %h want 0", btn_level);
        end
    endtask

    task automatic test_reset();
        int first_press = -1;
        int press_cnt   = 0;
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(4'hF);
            tests_run++;
            if ({btn_level, btn_press, btn_short, btn_long} !== 16'h0) begin
                tests_failed++;
                $display("FAIL reset_outputs cyc %0d: got %h want 0000", i,
                         {btn_level, btn_press, btn_short, btn_long});
            end
        end
        reset = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step(4'hF);
            if (btn_press != 4'h0) press_cnt++;
            if (btn_press == 4'hF && first_press < 0) first_press = i;
        end
        tests_run++;
        if (first_press !== 10) begin
            tests_failed++;
            $display("FAIL reset_press_time: got %0d want 10", first_press);
        end
        tests_run++;
        if (press_cnt !== 1) begin
            tests_failed++;
            $display("FAIL reset_press_count: got %0d want 1", press_cnt);
        end
        tests_run++;
        if (btn_level !== 4'hF) begin
            tests_failed++;
            $display("FAIL reset_level: got %h want f", btn_level);
        end
        release_all();
    endtask

    task automatic test_clean_press();
        int level_t = -1, press_t = -1, short_t = -1;
        int press_cnt = 0, short_cnt = 0, long_cnt = 0;
        for (int i = 1; i <= 50; i++) begin
            step((i <= 20) ? 4'h1 : 4'h0);
            if (btn_level[0] && level_t < 0) level_t = i;
            if (btn_press[0]) begin press_cnt++; press_t = i; end
            if (btn_short[0]) begin short_cnt++; short_t = i; end
            if (btn_long != 4'h0) long_cnt++;
        end
        tests_run++;
        if (level_t !== 10) begin
            tests_failed++;
            $display("FAIL clean_level_time: got %0d want 10", level_t);
        end
        tests_run++;
        if (press_cnt !== 1 || press_t !== 10) begin
            tests_failed++;
            $display("FAIL clean_press: got cnt %0d at %0d want cnt 1 at 10", press_cnt, press_t);
        end
        tests_run++;
        if (short_cnt !== 1 || short_t !== 30) begin
            tests_failed++;
            $display("FAIL clean_short: got cnt %0d at %0d want cnt 1 at 30", short_cnt, short_t);
        end
        tests_run++;
        if (long_cnt !== 0) begin
            tests_failed++;
            $display("FAIL clean_no_long: got %0d want 0", long_cnt);
        end
    endtask

    task automatic test_bounce();
        int early_activity = 0, press_cnt = 0, press_t = -1;
        logic r;
        for (int i = 1; i <= 60; i++) begin
            r = (i > 30) ? 1'b1 : ((((i - 1) / 3) % 2) == 0);
            step({2'b00, r, 1'b0});
            if (i < 40 && {btn_level, btn_press, btn_short, btn_long} != 16'h0) early_activity++;
            if (btn_press[1]) begin press_cnt++; press_t = i; end
        end
        tests_run++;
        if (early_activity !== 0) begin
            tests_failed++;
            $display("FAIL bounce_quiet: got %0d active cycles want 0", early_activity);
        end
        tests_run++;
        if (press_cnt !== 1 || press_t !== 40) begin
            tests_failed++;
            $display("FAIL bounce_press: got cnt %0d at %0d want cnt 1 at 40", press_cnt, press_t);
        end
        release_all();
    endtask

    task automatic test_long_press();
        int press_t = -1, long_t = -1, long_cnt = 0, short_cnt = 0, overlap = 0;
        for (int i = 1; i <= 130; i++) begin
            step((i <= 100) ? 4'h1 : 4'h0);
            if (btn_press[0]) press_t = i;
            if (btn_long[0]) begin long_cnt++; long_t = i; end
            if (btn_short[0]) short_cnt++;
            if (((btn_press & btn_short) | (btn_press & btn_long) | (btn_short & btn_long)) != 4'h0)
                overlap++;
        end
        tests_run++;
        if (press_t !== 10) begin
            tests_failed++;
            $display("FAIL long_press_time: got %0d want 10", press_t);
        end
        tests_run++;
        if (long_cnt !== 1 || long_t !== 50) begin
            tests_failed++;
            $display("FAIL long_pulse: got cnt %0d at %0d want cnt 1 at 50", long_cnt, long_t);
        end
        tests_run++;
        if (short_cnt !== 0) begin
            tests_failed++;
            $display("FAIL long_no_short: got %0d want 0", short_cnt);
        end
        tests_run++;
        if (overlap !== 0) begin
            tests_failed++;
            $display("FAIL long_exclusive: got %0d overlapping cycles want 0", overlap);
        end
        tests_run++;
        if (btn_level[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL long_release_level: got %b want 0", btn_level[0]);
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] press_at10 = 4'h0;
        int other_activity = 0;
        for (int i = 1; i <= 20; i++) begin
            step(4'hC);
            if (i == 10) press_at10 = btn_press;
            if ({btn_level[1:0], btn_press[1:0], btn_short[1:0], btn_long[1:0]} != 8'h0)
                other_activity++;
        end
        tests_run++;
        if (press_at10 !== 4'hC) begin
            tests_failed++;
            $display("FAIL simul_press: got %h want c", press_at10);
        end
        tests_run++;
        if (other_activity !== 0) begin
            tests_failed++;
            $display("FAIL simul_idle: got %0d active cycles want 0", other_activity);
        end
        release_all();
    endtask

    task automatic test_reset_mid_hold();
        int press2_t = -1, long_t = -1, long_cnt = 0, short_cnt = 0, rst_bad = 0;
        for (int i = 1; i <= 110; i++) begin
            reset = (i == 25 || i == 26);
            step((i <= 90) ? 4'h1 : 4'h0);
            if ((i == 25 || i == 26) && {btn_level, btn_press, btn_short, btn_long} != 16'h0)
                rst_bad++;
            if (btn_press[0] && i > 26 && press2_t < 0) press2_t = i;
            if (btn_long[0]) begin long_cnt++; long_t = i; end
            if (btn_short[0]) short_cnt++;
        end
        reset = 1'b0;
        tests_run++;
        if (rst_bad !== 0) begin
            tests_failed++;
            $display("FAIL midrst_outputs: got %0d bad cycles want 0", rst_bad);
        end
        tests_run++;
        if (press2_t !== 36) begin
            tests_failed++;
            $display("FAIL midrst_repress: got %0d want 36", press2_t);
        end
        tests_run++;
        if (long_cnt !== 1 || long_t !== 76) begin
            tests_failed++;
            $display("FAIL midrst_long: got cnt %0d at %0d want cnt 1 at 76", long_cnt, long_t);
        end
        tests_run++;
        if (short_cnt !== 0) begin
            tests_failed++;
            $display("FAIL midrst_no_short: got %0d want 0", short_cnt);
        end
    endtask

    task automatic test_full_scale();
        int press_t = -1, long_t = -1, long_cnt = 0;
        raw_full = 4'h1;
        for (int i = 1; i <= 20210; i++) begin
            step(4'h0);
            if (press_full[0] && press_t < 0) press_t = i;
            if (long_full[0]) begin long_cnt++; long_t = i; end
        end
        raw_full = 4'h0;
        tests_run++;
        if (press_t !== 202) begin
            tests_failed++;
            $display("FAIL full_press_time: got %0d want 202", press_t);
        end
        tests_run++;
        if (long_cnt !== 1 || long_t !== 20202) begin
            tests_failed++;
            $display("FAIL full_long: got cnt %0d at %0d want cnt 1 at 20202", long_cnt, long_t);
        end
    endtask

    initial begin
        reset    = 1'b1;
        btn_raw  = 4'h0;
        raw_full = 4'h0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_press();
        test_simultaneous();
        test_reset_mid_hold();
        release_all();
        test_full_scale();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
